// File: rtl/sym_fir_pipe.sv
// sym_fir_pipe: fully pipelined odd-length symmetric (linear-phase) FIR filter.
// The delay line shifts only on valid samples.
// Pre-add, multiply, a registered adder tree and the output stage run every cycle.
// The valid strobe rides a shift register matched to the datapath latency L = clog2(NH)+3.
// Optional macro FIR_SAT_EN: saturate the output window instead of wrapping.
// The coefficient address is one bit wider than clog2(NH) when NH is a power of two.
// This lets an out-of-range index (>= NH) be presented and ignored rather than alias onto tap 0.
module sym_fir_pipe #(
    parameter int NTAPS     = 31,
    parameter int DW        = 18,
    parameter int CW        = 18,
    parameter int OUT_SHIFT = 17,
    localparam int NH       = (NTAPS + 1) / 2,
    localparam int AW       = $clog2(NH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic                 out_valid,
    output logic signed [DW-1:0] out
);

    localparam int T   = $clog2(NH);
    localparam int L   = T + 3;
    localparam int PW  = DW + 1 + CW;
    localparam int SW  = PW + T;
    localparam int MSB = OUT_SHIFT + DW - 1;
    localparam logic [AW-1:0] NH_A = AW'(NH);

    // number of live operands at a given adder-tree level (level 0 = products)
    function automatic int level_count(input int lvl);
        return (NH + (1 << lvl) - 1) >> lvl;
    endfunction

    if ((NTAPS % 2) == 0 || NTAPS < 3) begin : g_bad_ntaps
        $error("sym_fir_pipe: NTAPS must be odd and >= 3");
    end
    if (OUT_SHIFT + DW > SW) begin : g_bad_shift
        $error("sym_fir_pipe: OUT_SHIFT+DW exceeds the full-precision sum width");
    end

    logic signed [DW-1:0] x_r  [NTAPS];
    logic signed [DW-1:0] xn_s [NTAPS];
    logic signed [DW:0]   s_r  [NH];
    logic signed [CW-1:0] b_r  [NH];
    logic signed [PW-1:0] p_r  [NH];
    logic [L-1:0]         vld_r;
    logic signed [DW-1:0] out_r;
    logic signed [DW-1:0] win_s;
    logic signed [SW-1:0] sum_s;
    logic                 unused_sum_s;

    // next view of the delay line: shifted by one when a sample arrives, else held
    always_comb begin
        for (int i = 0; i < NTAPS; i++) xn_s[i] = x_r[i];
        if (in_valid) begin
            xn_s[0] = in;
            for (int i = 1; i < NTAPS; i++) xn_s[i] = x_r[i-1];
        end else begin
            for (int i = 0; i < NTAPS; i++) xn_s[i] = x_r[i];
        end
    end

    // delay line register
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) x_r[i] <= '0;
        end else begin
            for (int i = 0; i < NTAPS; i++) x_r[i] <= xn_s[i];
        end
    end

    // pre-add of mirrored taps on the updated window; centre tap passes sign-extended
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NH; i++) s_r[i] <= '0;
        end else begin
            for (int i = 0; i < NH - 1; i++)
                s_r[i] <= {xn_s[i][DW-1], xn_s[i]} + {xn_s[NTAPS-1-i][DW-1], xn_s[NTAPS-1-i]};
            s_r[NH-1] <= {xn_s[NH-1][DW-1], xn_s[NH-1]};
        end
    end

    // coefficient store; out-of-range addresses leave every coefficient untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NH; i++) b_r[i] <= '0;
        end else if (coef_we && (coef_addr < NH_A)) begin
            b_r[coef_addr] <= coef_data;
        end else begin
            for (int i = 0; i < NH; i++) b_r[i] <= b_r[i];
        end
    end

    // full-precision products of pre-added samples and coefficients
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NH; i++) p_r[i] <= '0;
        end else begin
            for (int i = 0; i < NH; i++)
                p_r[i] <= $signed({{CW{s_r[i][DW]}}, s_r[i]}) *
                          $signed({{(DW + 1){b_r[i][CW-1]}}, b_r[i]});
        end
    end

    // registered pairwise adder tree; an odd leftover operand is carried through its level
    for (genvar l = 0; l <= T; l++) begin : g_lvl
        localparam int NCUR  = level_count(l);
        localparam int NPREV = level_count((l == 0) ? 0 : l - 1);
        for (genvar j = 0; j < NCUR; j++) begin : g_n
            logic signed [SW-1:0] r;
            if (l == 0) begin : g_leaf
                assign r = {{T{p_r[j][PW-1]}}, p_r[j]};
            end else if (2 * j + 1 < NPREV) begin : g_add
                // sum of one operand pair from the level below
                always_ff @(posedge clk) begin
                    if (reset) r <= '0;
                    else       r <= g_lvl[l-1].g_n[2*j].r + g_lvl[l-1].g_n[2*j+1].r;
                end
            end else begin : g_pass
                // odd operand carried forward so every path has equal latency
                always_ff @(posedge clk) begin
                    if (reset) r <= '0;
                    else       r <= g_lvl[l-1].g_n[2*j].r;
                end
            end
        end
    end

    assign sum_s        = g_lvl[T].g_n[0].r;
    assign unused_sum_s = ^sum_s;

    // select the output window from the full sum (floor truncation, optional clamp)
    always_comb begin
        win_s = sum_s[MSB:OUT_SHIFT];
`ifdef FIR_SAT_EN
        if (!(&sum_s[SW-1:MSB]) && (|sum_s[SW-1:MSB])) begin
            if (sum_s[SW-1]) win_s = {1'b1, {(DW - 1){1'b0}}};
            else             win_s = {1'b0, {(DW - 1){1'b1}}};
        end else begin
            win_s = sum_s[MSB:OUT_SHIFT];
        end
`endif
    end

    // valid strobe travels alongside the data with the same latency
    always_ff @(posedge clk) begin
        if (reset) vld_r <= '0;
        else       vld_r <= {vld_r[L-2:0], in_valid};
    end

    // output register loads only when a valid result emerges, otherwise holds
    always_ff @(posedge clk) begin
        if (reset)             out_r <= '0;
        else if (vld_r[L-2])   out_r <= win_s;
        else                   out_r <= out_r;
    end

    assign out_valid = vld_r[L-1];
    assign out       = out_r;

endmodule
